pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive-side counterpart to the `pwm` generator. Typical uses are loopback-checking the audio DAC output on the board and decoding PWM from an external source over a PMOD pin. The asynchronous input is synchronized internally. One result pair is produced per complete rising-to-rising cycle, and a timeout flags a missing or stuck signal.

---
 rtl/pwm_capture.sv | 120 ++++++++++++
 tb/tb_pwm_capture.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes an asynchronous PWM input and measures its high
// time and period in clock cycles, with a timeout for missing or stuck input.
module pwm_capture #(
   parameter int WIDTH = 9
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pwm,
   output logic [WIDTH-1:0] o_high,
   output logic [WIDTH-1:0] o_period,
   output logic             o_valid,
   output logic             o_timeout,
   output logic             o_level
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_HIGH,
      ST_LOW
   } state_t;

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             s1;
   logic             s2;
   logic             s3;
   logic [1:0]       fill;
   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] high_lat;
   logic             rise;
   logic             fall;
   logic             at_max;

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign at_max  = (cnt == MAX);
   assign o_level = s2;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         fill      <= 2'b00;
         state     <= ST_IDLE;
         cnt       <= '0;
         high_lat  <= '0;
         o_high    <= '0;
         o_period  <= '0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         s1      <= i_pwm;
         s2      <= s1;
         s3      <= s2;
         fill    <= {fill[0], 1'b1};
         o_valid <= 1'b0;

         case (state)
            // The cleared synchronizer reads low right after reset; only a
            // low that has really been sampled may arm the measurement.
            ST_IDLE: begin
               cnt <= '0;
               if (fill[1] && !s2) begin
                  state <= ST_ARMED;
               end
            end

            ST_ARMED: begin
               cnt <= '0;
               if (rise) begin
                  cnt   <= ONE;
                  state <= ST_HIGH;
               end
            end

            ST_HIGH: begin
               if (at_max) begin
                  o_timeout <= 1'b1;
                  cnt       <= '0;
                  state     <= ST_IDLE;
               end else begin
                  cnt <= cnt + ONE;
                  if (fall) begin
                     high_lat <= cnt;
                     state    <= ST_LOW;
                  end
               end
            end

            // A rise with cnt at MAX is still a valid period: the edge wins.
            ST_LOW: begin
               if (rise) begin
                  o_high    <= high_lat;
                  o_period  <= cnt;
                  o_valid   <= 1'b1;
                  o_timeout <= 1'b0;
                  cnt       <= ONE;
                  state     <= ST_HIGH;
               end else if (at_max) begin
                  o_timeout <= 1'b1;
                  cnt       <= '0;
                  state     <= ST_IDLE;
               end else begin
                  cnt <= cnt + ONE;
               end
            end

            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture (WIDTH=9): loopback-style periods,
// 1-clock pulses, timeouts, period boundaries, reset mid-measurement.
module tb_pwm_capture;

   localparam int W = 9;

   logic         clk;
   logic         rst_n;
   logic         pwm;
   logic [W-1:0] high;
   logic [W-1:0] period;
   logic         valid;
   logic         timeout;
   logic         level;

   int compared = 0;
   int mismatched = 0;

   int cyc = 0;
   int valid_cnt = 0;
   int last_valid_cyc = 0;
   int prev_valid_cyc = 0;
   int to_rise_cyc = 0;
   logic to_fall_valid = 1'b0;
   logic to_prev = 1'b0;

   pwm_capture #(.WIDTH(W)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_pwm     (pwm),
      .o_high    (high),
      .o_period  (period),
      .o_valid   (valid),
      .o_timeout (timeout),
      .o_level   (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         valid_cnt      = valid_cnt + 1;
         prev_valid_cyc = last_valid_cyc;
         last_valid_cyc = cyc;
         $display("valid  cyc=%0d high=%0d period=%0d", cyc, high, period);
      end
      if (timeout === 1'b1 && to_prev !== 1'b1) begin
         to_rise_cyc = cyc;
         $display("timeout set cyc=%0d", cyc);
      end
      if (timeout === 1'b0 && to_prev === 1'b1) to_fall_valid = valid;
      to_prev = timeout;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish, expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input logic lvl);
      pwm = lvl;
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic lvl, input int n);
      for (int i = 0; i < n; i++) tick(lvl);
   endtask

   task automatic pwm_cycles(input int hi, input int per, input int n);
      for (int k = 0; k < n; k++) begin
         hold(1'b1, hi);
         hold(1'b0, per - hi);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hold(1'b1, 3);
      compared++; if (high !== 9'd0) begin mismatched++; $display("FAIL reset_high: got %0d expected 0", high); end
      compared++; if (period !== 9'd0) begin mismatched++; $display("FAIL reset_period: got %0d expected 0", period); end
      compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", valid); end
      compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      compared++; if (level !== 1'b0) begin mismatched++; $display("FAIL reset_level: got %b expected 0", level); end
   endtask

   task automatic test_loopback();
      rst_n = 1'b1;
      hold(1'b0, 5);
      pwm_cycles(100, 256, 4);
      compared++; if (valid_cnt !== 3) begin mismatched++; $display("FAIL loop_count: got %0d expected 3", valid_cnt); end
      compared++; if (last_valid_cyc - prev_valid_cyc !== 256) begin mismatched++; $display("FAIL loop_spacing: got %0d expected 256", last_valid_cyc - prev_valid_cyc); end
      compared++; if (high !== 9'd100) begin mismatched++; $display("FAIL loop_high: got %0d expected 100", high); end
      compared++; if (period !== 9'd256) begin mismatched++; $display("FAIL loop_period: got %0d expected 256", period); end
      compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL loop_timeout: got %b expected 0", timeout); end
   endtask

   task automatic test_stuck_low();
      int v;
      v = valid_cnt;
      hold(1'b0, 600);
      compared++; if (valid_cnt !== v) begin mismatched++; $display("FAIL low_novalid: got %0d expected %0d", valid_cnt, v); end
      compared++; if (timeout !== 1'b1) begin mismatched++; $display("FAIL low_timeout: got %b expected 1", timeout); end
      compared++; if (to_rise_cyc - last_valid_cyc !== 511) begin mismatched++; $display("FAIL low_to_delay: got %0d expected 511", to_rise_cyc - last_valid_cyc); end
      compared++; if (high !== 9'd100) begin mismatched++; $display("FAIL low_hold_high: got %0d expected 100", high); end
      compared++; if (period !== 9'd256) begin mismatched++; $display("FAIL low_hold_period: got %0d expected 256", period); end
      pwm_cycles(100, 256, 2);
      compared++; if (valid_cnt !== v + 1) begin mismatched++; $display("FAIL resume_count: got %0d expected %0d", valid_cnt, v + 1); end
      compared++; if (to_fall_valid !== 1'b1) begin mismatched++; $display("FAIL resume_clear_with_valid: got %b expected 1", to_fall_valid); end
      compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL resume_timeout: got %b expected 0", timeout); end
      compared++; if (period !== 9'd256) begin mismatched++; $display("FAIL resume_period: got %0d expected 256", period); end
   endtask

   task automatic test_short_pulse();
      int v;
      v = valid_cnt;
      pwm_cycles(1, 4, 5);
      compared++; if (valid_cnt !== v + 5) begin mismatched++; $display("FAIL short_count: got %0d expected %0d", valid_cnt, v + 5); end
      compared++; if (high !== 9'd1) begin mismatched++; $display("FAIL short_high: got %0d expected 1", high); end
      compared++; if (period !== 9'd4) begin mismatched++; $display("FAIL short_period: got %0d expected 4", period); end
      compared++; if (last_valid_cyc - prev_valid_cyc !== 4) begin mismatched++; $display("FAIL short_spacing: got %0d expected 4", last_valid_cyc - prev_valid_cyc); end
   endtask

   task automatic test_boundary();
      int v;
      v = valid_cnt;
      pwm_cycles(10, 511, 1);
      pwm_cycles(10, 512, 1);
      hold(1'b1, 5);
      compared++; if (valid_cnt !== v + 2) begin mismatched++; $display("FAIL p512_count: got %0d expected %0d", valid_cnt, v + 2); end
      compared++; if (period !== 9'd511) begin mismatched++; $display("FAIL p511_period: got %0d expected 511", period); end
      compared++; if (high !== 9'd10) begin mismatched++; $display("FAIL p511_high: got %0d expected 10", high); end
      compared++; if (timeout !== 1'b1) begin mismatched++; $display("FAIL p512_timeout: got %b expected 1", timeout); end
      hold(1'b0, 5);
      pwm_cycles(10, 20, 1);
      hold(1'b1, 600);
      compared++; if (valid_cnt !== v + 3) begin mismatched++; $display("FAIL stuckhi_count: got %0d expected %0d", valid_cnt, v + 3); end
      compared++; if (high !== 9'd10) begin mismatched++; $display("FAIL stuckhi_high: got %0d expected 10", high); end
      compared++; if (period !== 9'd20) begin mismatched++; $display("FAIL stuckhi_period: got %0d expected 20", period); end
      compared++; if (timeout !== 1'b1) begin mismatched++; $display("FAIL stuckhi_timeout: got %b expected 1", timeout); end
      compared++; if (to_rise_cyc - last_valid_cyc !== 511) begin mismatched++; $display("FAIL stuckhi_to_delay: got %0d expected 511", to_rise_cyc - last_valid_cyc); end
      compared++; if (to_fall_valid !== 1'b1) begin mismatched++; $display("FAIL stuckhi_clear_with_valid: got %b expected 1", to_fall_valid); end
   endtask

   task automatic test_reset_mid();
      int v;
      hold(1'b0, 5);
      hold(1'b1, 10);
      v = valid_cnt;
      rst_n = 1'b0;
      tick(1'b1);
      rst_n = 1'b1;
      compared++; if (high !== 9'd0) begin mismatched++; $display("FAIL mid_high: got %0d expected 0", high); end
      compared++; if (period !== 9'd0) begin mismatched++; $display("FAIL mid_period: got %0d expected 0", period); end
      compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid: got %b expected 0", valid); end
      compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL mid_timeout: got %b expected 0", timeout); end
      compared++; if (level !== 1'b0) begin mismatched++; $display("FAIL mid_level: got %b expected 0", level); end
      hold(1'b1, 40);
      hold(1'b0, 50);
      pwm_cycles(30, 70, 1);
      compared++; if (valid_cnt !== v) begin mismatched++; $display("FAIL mid_novalid: got %0d expected %0d", valid_cnt, v); end
      tick(1'b1);
      compared++; if (level !== 1'b0) begin mismatched++; $display("FAIL lat_level_n: got %b expected 0", level); end
      compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL lat_valid_n: got %b expected 0", valid); end
      tick(1'b1);
      compared++; if (level !== 1'b1) begin mismatched++; $display("FAIL lat_level_n1: got %b expected 1", level); end
      compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL lat_valid_n1: got %b expected 0", valid); end
      tick(1'b1);
      compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL lat_valid_n2: got %b expected 1", valid); end
      compared++; if (high !== 9'd30) begin mismatched++; $display("FAIL release_high: got %0d expected 30", high); end
      compared++; if (period !== 9'd70) begin mismatched++; $display("FAIL release_period: got %0d expected 70", period); end
      tick(1'b0);
      compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL lat_valid_width: got %b expected 0", valid); end
      compared++; if (valid_cnt !== v + 1) begin mismatched++; $display("FAIL release_count: got %0d expected %0d", valid_cnt, v + 1); end
   endtask

   initial begin
      rst_n = 1'b0;
      pwm   = 1'b0;
      test_reset();
      test_loopback();
      test_stuck_low();
      test_short_pulse();
      test_boundary();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
